// File: rtl/inst_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loader_pkg (package)
// Purpose  : Shared types and constants for the instruction stream loader:
//            FSM state encoding, error codes, the halt word used to pad
//            unused instruction memory, and small state-decode helpers.
// Ports    : none (package)
// Options  : INST_LOADER_FILL_EN enables the FILL state in the loader top.
// Revision : 1.0  initial release
// ============================================================================
package loader_pkg;

  // Width of the big-endian word-count header, in bytes.
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_FILL   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  // Decodes as an unknown opcode, so the CPU stops if it runs past the program.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // States in which a stream byte may be accepted.
  function automatic logic is_accepting(input state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

  // States in which a new load may be requested (everything else is busy).
  function automatic logic is_resting(input state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_stream_loader_if
// Purpose  : Groups the byte-stream handshake and the instruction memory
//            write port of the loader.
// Signals  : in_valid/in_byte  source -> loader stream byte
//            in_ready          loader -> source accept
//            mem_we/mem_addr/mem_wdata  loader -> instruction memory write
// Modports : master = stream source / memory side, slave = loader.
// Revision : 1.0  initial release
// ============================================================================
interface inst_stream_loader_if #(
  parameter int INST_ADDR_BIT = 10
) ();

  logic                     in_valid;
  logic [7:0]               in_byte;
  logic                     in_ready;
  logic                     mem_we;
  logic [INST_ADDR_BIT-1:0] mem_addr;
  logic [31:0]              mem_wdata;

  modport master (
    output in_valid,
    output in_byte,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_byte,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/inst_stream_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Assembles big-endian 32-bit words from a byte stream. The first
//            byte of a word lands in bits [31:24].
// Ports    : clock, reset      clock / synchronous active-high reset
//            clear             restart at byte 0 of a word
//            byte_valid        byte_in is consumed this cycle
//            byte_in[7:0]      stream byte
//            word_valid        combinational pulse with the 4th byte of a word
//            word[31:0]        assembled word, valid while word_valid is high
// Revision : 1.0  initial release
// ============================================================================
module byte_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  // Holds the three earlier bytes of the word being assembled.
  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shift_q <= 24'd0;
      idx_q   <= 2'd0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      idx_q   <= idx_q + 2'd1;
    end
  end

  // The 4th byte is merged straight through so the caller can register the
  // complete word on the same edge that accepts it.
  assign word_valid = byte_valid && (idx_q == 2'd3);
  assign word       = {shift_q, byte_in};

endmodule
`default_nettype wire

// File: rtl/inst_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_stream_loader
// Purpose  : Receives a program as a byte stream (2-byte big-endian word
//            count, N*4 payload bytes, XOR checksum byte), writes the words
//            into instruction memory and pulses cpu_start after a verified
//            load.
// Ports    : clock, reset      clock / synchronous active-high reset
//            load_req          start a new load (ignored while busy)
//            bus (slave)       stream handshake + memory write port
//            cpu_start         one-cycle pulse on entry to DONE
//            busy              load in progress; hold the CPU in reset
//            done              level, high in DONE
//            error[1:0]        00 none, 01 length overflow, 10 checksum
// Options  : INST_LOADER_FILL_EN - pad addresses N..depth-1 with the halt
//            word after a good checksum, before DONE.
// Revision : 1.0  initial release
// ============================================================================
module inst_stream_loader
  import loader_pkg::*;
#(
  parameter int INST_ADDR_BIT = 10,
  parameter int LEN_BYTES     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load_req,
  inst_stream_loader_if.slave  bus,
  output logic                 cpu_start,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           error
);

  if (LEN_BYTES != HDR_BYTES) begin : g_len_bytes_check
    $error("inst_stream_loader: LEN_BYTES must be 2");
  end

  // Depth as an (INST_ADDR_BIT+1)-bit value; N may equal the full depth.
  localparam logic [INST_ADDR_BIT:0] DEPTH_W = {1'b1, {INST_ADDR_BIT{1'b0}}};
  localparam logic [INST_ADDR_BIT:0] ONE_W   = {{INST_ADDR_BIT{1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [7:0]               len_hi_q;
  logic [INST_ADDR_BIT:0]   n_q;
  logic [INST_ADDR_BIT:0]   wcnt_q;
  logic [7:0]               csum_q;
  logic [1:0]               error_q;
  logic                     in_ready_q;
  logic                     mem_we_q;
  logic [INST_ADDR_BIT-1:0] mem_addr_q;
  logic [31:0]              mem_wdata_q;
  logic                     cpu_start_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     xfer;
  logic                     load_start;
  logic [31:0]              len_w;
  logic                     len_over;
  logic                     len_zero;
  logic [INST_ADDR_BIT:0]   wcnt_inc;
  logic                     last_word;
  logic                     csum_ok;
  logic                     word_valid;
  logic [31:0]              word;

  assign xfer       = bus.in_valid && in_ready_q;
  assign load_start = load_req && is_resting(state_q);
  assign len_w      = {16'd0, len_hi_q, bus.in_byte};
  assign len_over   = len_w > 32'(DEPTH_W);
  assign len_zero   = (len_w == 32'd0);
  assign wcnt_inc   = wcnt_q + ONE_W;
  assign last_word  = (wcnt_inc == n_q);
  assign csum_ok    = (bus.in_byte == csum_q);

  byte_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (xfer && (state_q == ST_DATA)),
    .byte_in    (bus.in_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (load_req) state_d = ST_LEN_HI;
      ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
      ST_LEN_LO: begin
        if (xfer) begin
          if (len_over)      state_d = ST_ERR;
          else if (len_zero) state_d = ST_CSUM;
          else               state_d = ST_DATA;
        end
      end
      // word_valid already implies a byte transfer in DATA.
      ST_DATA: if (word_valid && last_word) state_d = ST_CSUM;
      ST_CSUM: begin
        if (xfer) begin
          if (!csum_ok) begin
            state_d = ST_ERR;
          end else begin
`ifdef INST_LOADER_FILL_EN
            state_d = (n_q == DEPTH_W) ? ST_DONE : ST_FILL;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef INST_LOADER_FILL_EN
      ST_FILL: if (wcnt_inc == DEPTH_W) state_d = ST_DONE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= 8'd0;
      n_q         <= '0;
      wcnt_q      <= '0;
      csum_q      <= 8'd0;
      error_q     <= ERR_NONE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      cpu_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Status outputs are decoded from the next state so they line up with
      // the state register rather than lagging it by a cycle.
      in_ready_q  <= is_accepting(state_d);
      busy_q      <= !is_resting(state_d);
      done_q      <= (state_d == ST_DONE);
      cpu_start_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
      mem_we_q    <= 1'b0;

      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (load_req) begin
            error_q  <= ERR_NONE;
            wcnt_q   <= '0;
            csum_q   <= 8'd0;
            n_q      <= '0;
            len_hi_q <= 8'd0;
          end
        end
        ST_LEN_HI: if (xfer) len_hi_q <= bus.in_byte;
        ST_LEN_LO: begin
          if (xfer) begin
            if (len_over) error_q <= ERR_LEN;
            else          n_q     <= len_w[INST_ADDR_BIT:0];
          end
        end
        ST_DATA: begin
          if (xfer) csum_q <= csum_q ^ bus.in_byte;
          if (word_valid) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wcnt_q[INST_ADDR_BIT-1:0];
            mem_wdata_q <= word;
            wcnt_q      <= wcnt_inc;
          end
        end
        ST_CSUM: if (xfer && !csum_ok) error_q <= ERR_CSUM;
`ifdef INST_LOADER_FILL_EN
        ST_FILL: begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= wcnt_q[INST_ADDR_BIT-1:0];
          mem_wdata_q <= HALT_WORD;
          wcnt_q      <= wcnt_inc;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_start     = cpu_start_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_stream_loader
// Purpose  : Self-checking bench for inst_stream_loader. Expected memory
//            writes go into a scoreboard queue when a stream is issued; a
//            monitor pops and compares on every mem_we.
// Options  : INST_LOADER_FILL_EN adds the expected halt-word fill writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_stream_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
`ifdef INST_LOADER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0;
  logic       cpu_start;
  logic       busy;
  logic       done;
  logic [1:0] error;

  always #5 clock = ~clock;

  inst_stream_loader_if #(.INST_ADDR_BIT(AW)) bus ();

  inst_stream_loader #(.INST_ADDR_BIT(AW), .LEN_BYTES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .load_req  (load_req),
    .bus       (bus),
    .cpu_start (cpu_start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int xfer_cnt = 0;
  logic [AW+31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) xfer_cnt++;
    if (cpu_start === 1'b1) start_cnt++;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e[AW+31:32]));
        chk("wr_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic push_wr(input int addr, input logic [31:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  task automatic push_fill(input int n);
    if (FILL_EN) for (int a = n; a < DEPTH; a++) push_wr(a, 32'hFFFF_FFFF);
  endtask

  // All driving happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    start_cnt = 0;
    xfer_cnt  = 0;
    load_req  = 1'b1;
    tick();
    load_req  = 1'b0;
  endtask

  // Holds the byte until the DUT accepts it, then idles for 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   guard;
    logic rdy;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    guard = 0;
    do begin
      @(negedge clock);
      rdy = bus.in_ready;
      tick();
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL handshake_timeout: got in_ready 0 for byte %h, expected 1", b);
    end
    bus.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic finish_check(input logic exp_done, input logic [1:0] exp_err, input int exp_starts);
    int guard;
    guard = 0;
    while (busy !== 1'b0 && guard < 5000) begin
      tick();
      guard++;
    end
    chk("busy_released", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("done", 32'(done), 32'(exp_done));
    chk("error", 32'(error), 32'(exp_err));
    chk("cpu_start_pulses", 32'(start_cnt), 32'(exp_starts));
    chk("writes_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Two-word program; payload XOR is 8C^01^00^04^20^22^00^05 = 8E.
  logic [7:0] prog2[$] = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                           8'h20, 8'h22, 8'h00, 8'h05, 8'h8E};
  logic [7:0] prog2_bad[$] = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00, 8'h04,
                               8'h20, 8'h22, 8'h00, 8'h05, 8'h00};
  logic [7:0] prog_over[$] = '{8'h04, 8'h01};
  logic [7:0] prog_empty[$] = '{8'h00, 8'h00, 8'h00};
  // 12^34^56^78 = 08
  logic [7:0] prog1[$] = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
  logic [7:0] prog_cut[$] = '{8'h00, 8'h02, 8'h8C, 8'h01, 8'h00};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cpu_start", 32'(cpu_start), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    // Good two-word load, back-to-back bytes
    start_load();
    chk("len_hi_in_ready", 32'(bus.in_ready), 32'd1);
    chk("len_hi_busy", 32'(busy), 32'd1);
    push_wr(0, 32'h8C01_0004);
    push_wr(1, 32'h2022_0005);
    push_fill(2);
    send_stream(prog2, 0);
    finish_check(1'b1, 2'b00, 1);

    // Same program, wrong checksum
    start_load();
    chk("reload_error_cleared", 32'(error), 32'd0);
    push_wr(0, 32'h8C01_0004);
    push_wr(1, 32'h2022_0005);
    send_stream(prog2_bad, 0);
    finish_check(1'b0, 2'b10, 0);

    // N = 1025 overflows a 1024-word memory
    start_load();
    send_stream(prog_over, 0);
    chk("over_in_ready", 32'(bus.in_ready), 32'd0);
    finish_check(1'b0, 2'b01, 0);

    // Empty program
    start_load();
    push_fill(0);
    send_stream(prog_empty, 0);
    finish_check(1'b1, 2'b00, 1);

    // One word with in_valid toggling every other cycle
    start_load();
    push_wr(0, 32'h1234_5678);
    push_fill(1);
    send_stream(prog1, 1);
    finish_check(1'b1, 2'b00, 1);
    chk("handshake_count", 32'(xfer_cnt), 32'd7);

    // Reset on the edge that accepts the 6th byte: that word is never written
    start_load();
    send_stream(prog_cut, 0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h04;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (5) tick();
    chk("midrst_cpu_start", 32'(start_cnt), 32'd0);
    chk("midrst_writes", 32'(exp_q.size()), 32'd0);

    // A full load after the interrupted one
    start_load();
    push_wr(0, 32'h8C01_0004);
    push_wr(1, 32'h2022_0005);
    push_fill(2);
    send_stream(prog2, 0);
    finish_check(1'b1, 2'b00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
